// File: rtl/endian_swap_stream_if.sv
// -----------------------------------------------------------------------------
// endian_swap_stream_if
//   Valid/ready beat stream used on both sides of endian_swap_stream.
//
//   Signals
//     data   DATA_W  beat payload
//     valid  1       producer holds a valid beat
//     ready  1       consumer accepts the beat this cycle
//
//   Modports
//     master  producer side: drives data/valid, observes ready
//     slave   consumer side: observes data/valid, drives ready
// -----------------------------------------------------------------------------
interface endian_swap_stream_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface : endian_swap_stream_if

// File: rtl/endian_swap_stream.sv
// -----------------------------------------------------------------------------
// endian_swap_stream
//   Streaming endianness converter. Each DATA_W beat is byte-reordered by the
//   mode latched at run, passed through a registered output stage backed by a
//   one-entry skid buffer, and a run of len beats ends with a one-cycle done.
//
//   Modes: 0 pass, 1 swap bytes in 16-bit lanes, 2 swap bytes in 32-bit lanes,
//          3 reverse all bytes of the beat.
//   Build option: define SWAP_BIT_REVERSE_EN to widen mode to 3 bits and add
//          mode 4 (reverse bit order inside each byte); modes 5-7 pass.
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   asynchronous reset, active low
//     run      in   start pulse; samples mode, len, enabled while idle
//     enabled  in   0 forces pass-through for the run
//     mode     in   byte-order mode (2 bits, 3 with SWAP_BIT_REVERSE_EN)
//     len      in   beats to accept in the run (0 gives an immediate done)
//     in0      slave stream  input beats
//     out0     master stream converted beats
//     busy     out  run in progress
//     done     out  one-cycle pulse after the last beat has left
// -----------------------------------------------------------------------------
module endian_swap_stream #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  enabled,
`ifdef SWAP_BIT_REVERSE_EN
    input  logic [2:0]            mode,
`else
    input  logic [1:0]            mode,
`endif
    input  logic [LEN_W-1:0]      len,
    endian_swap_stream_if.slave   in0,
    endian_swap_stream_if.master  out0,
    output logic                  busy,
    output logic                  done
);

    localparam int MODE_W    = $bits(mode);
    localparam int NUM_BYTES = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                skid_valid_q, skid_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   conv_data;
    logic                accept;
    logic                out_fire;

    // in_ready_q is only high in ACTIVE with an empty skid, so an accepted
    // beat always has somewhere to land.
    assign accept   = in0.valid && in_ready_q;
    assign out_fire = out_valid_q && out0.ready;

    // Byte reordering of the incoming beat under the latched mode.
    // NOTE: every always_comb output gets a value on every path (here the
    // pass-through default) so no latch is inferred.
    always_comb begin
        conv_data = in0.data;
        for (int k = 0; k < NUM_BYTES; k++) begin
            case (mode_q)
                MODE_W'(1): conv_data[8*k +: 8] = in0.data[8*(k ^ 1) +: 8];
                MODE_W'(2): conv_data[8*k +: 8] = in0.data[8*(k ^ 3) +: 8];
                MODE_W'(3): conv_data[8*k +: 8] = in0.data[8*(NUM_BYTES-1-k) +: 8];
`ifdef SWAP_BIT_REVERSE_EN
                MODE_W'(4): begin
                    for (int b = 0; b < 8; b++) begin
                        conv_data[8*k + b] = in0.data[8*k + 7 - b];
                    end
                end
`endif
                default:    conv_data[8*k +: 8] = in0.data[8*k +: 8];
            endcase
        end
    end

    // Next-state logic: output/skid pipeline followed by the run FSM.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        len_d        = len_q;
        mode_d       = mode_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        done_d       = 1'b0;

        if (out_fire) begin
            if (skid_valid_q) begin
                // Skid holds the older beat; accept is impossible here.
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d   = conv_data;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (accept) begin
                out_data_d  = conv_data;
                out_valid_d = 1'b1;
            end
        end else if (accept) begin
            // Output stalled: park the beat so ready can drop a cycle late.
            skid_data_d  = conv_data;
            skid_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (run) begin
                    mode_d  = enabled ? mode : '0;
                    len_d   = len;
                    count_d = '0;
                    if (len != '0) state_d = ACTIVE;
                    else           done_d  = 1'b1;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    count_d = count_q + LEN_W'(1);
                    if (count_q == len_q - LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_q && !skid_valid_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == ACTIVE) && !skid_valid_d;
        busy_d     = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the data registers are reset too, because out0 must read 0 in
    // reset; they are small enough that this costs nothing meaningful.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            len_q        <= '0;
            mode_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            len_q        <= len_d;
            mode_q       <= mode_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in0.ready  = in_ready_q;
    assign out0.data  = out_data_q;
    assign out0.valid = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : endian_swap_stream

// File: tb/tb_endian_swap_stream.sv
// -----------------------------------------------------------------------------
// tb_endian_swap_stream
//   Directed self-checking bench for endian_swap_stream. A 32-bit instance
//   covers modes, stalls, len=0, run-while-busy and mid-run reset; a 64-bit
//   instance covers full-width reversal and the enabled=0 override.
// -----------------------------------------------------------------------------
module tb_endian_swap_stream;

`ifdef SWAP_BIT_REVERSE_EN
    localparam int MODE_W = 3;
`else
    localparam int MODE_W = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              a_run, a_en, a_busy, a_done;
    logic [MODE_W-1:0] a_mode;
    logic [15:0]       a_len;
    logic              b_run, b_en, b_busy, b_done;
    logic [MODE_W-1:0] b_mode;
    logic [15:0]       b_len;

    endian_swap_stream_if #(.DATA_W(32)) a_in  ();
    endian_swap_stream_if #(.DATA_W(32)) a_out ();
    endian_swap_stream_if #(.DATA_W(64)) b_in  ();
    endian_swap_stream_if #(.DATA_W(64)) b_out ();

    endian_swap_stream #(.DATA_W(32), .LEN_W(16)) dut_a (
        .clk(clk), .rst(rst), .run(a_run), .enabled(a_en), .mode(a_mode),
        .len(a_len), .in0(a_in), .out0(a_out), .busy(a_busy), .done(a_done)
    );

    endian_swap_stream #(.DATA_W(64), .LEN_W(16)) dut_b (
        .clk(clk), .rst(rst), .run(b_run), .enabled(b_en), .mode(b_mode),
        .len(b_len), .in0(b_in), .out0(b_out), .busy(b_busy), .done(b_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    logic [31:0] got[$];
    int          got_cyc[$];

    // Monitor: records every beat leaving dut_a and counts done pulses.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (a_out.valid && a_out.ready) begin
            got.push_back(a_out.data);
            got_cyc.push_back(cyc);
        end
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_a(input int m, input int l, input logic en);
        a_mode = MODE_W'(m);
        a_len  = 16'(l);
        a_en   = en;
        a_run  = 1'b1;
        step();
        a_run  = 1'b0;
    endtask

    task automatic start_b(input int m, input int l, input logic en);
        b_mode = MODE_W'(m);
        b_len  = 16'(l);
        b_en   = en;
        b_run  = 1'b1;
        step();
        b_run  = 1'b0;
    endtask

    task automatic send_a(input logic [31:0] v);
        int n = 0;
        a_in.data  = v;
        a_in.valid = 1'b1;
        while (a_in.ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("send_a_ready_seen", 64'(n < 20), 64'd1);
        step();
        a_in.valid = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] v);
        int n = 0;
        b_in.data  = v;
        b_in.valid = 1'b1;
        while (b_in.ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("send_b_ready_seen", 64'(n < 20), 64'd1);
        step();
        b_in.valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit use_b);
        int n = 0;
        while ((use_b ? b_done : a_done) !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 64'(n < 50), 64'd1);
        check({tag, "_busy_low_at_done"}, 64'(use_b ? b_busy : a_busy), 64'd0);
    endtask

    initial begin
        int d0;
        a_run = 0; a_en = 0; a_mode = '0; a_len = '0;
        b_run = 0; b_en = 0; b_mode = '0; b_len = '0;
        a_in.data = '0; a_in.valid = 0; a_out.ready = 0;
        b_in.data = '0; b_in.valid = 0; b_out.ready = 0;

        // Reset state
        step();
        step();
        check("rst_out_valid", 64'(a_out.valid), 64'd0);
        check("rst_out_data",  64'(a_out.data),  64'd0);
        check("rst_in_ready",  64'(a_in.ready),  64'd0);
        check("rst_busy",      64'(a_busy),      64'd0);
        check("rst_done",      64'(a_done),      64'd0);
        rst = 1'b1;
        a_out.ready = 1'b1;
        b_out.ready = 1'b1;
        step();

        // Mode 1, single beat
        start_a(1, 1, 1'b1);
        check("t1_busy",     64'(a_busy),     64'd1);
        check("t1_in_ready", 64'(a_in.ready), 64'd1);
        send_a(32'h11223344);
        check("t1_out_valid", 64'(a_out.valid), 64'd1);
        check("t1_out_data",  64'(a_out.data),  64'h22114433);
        wait_done("t1", 1'b0);
        step();
        check("t1_done_one_cycle", 64'(a_done), 64'd0);
        check("t1_beats", 64'(got.size()), 64'd1);
        check("t1_beat0", 64'(got[0]), 64'h22114433);
        got.delete();
        got_cyc.delete();

        // Mode 2, three beats back-to-back
        start_a(2, 3, 1'b1);
        send_a(32'h11223344);
        send_a(32'hAABBCCDD);
        send_a(32'h01020304);
        check("t2_ready_low_after_last", 64'(a_in.ready), 64'd0);
        wait_done("t2", 1'b0);
        check("t2_beats", 64'(got.size()), 64'd3);
        check("t2_beat0", 64'(got[0]), 64'h44332211);
        check("t2_beat1", 64'(got[1]), 64'hDDCCBBAA);
        check("t2_beat2", 64'(got[2]), 64'h04030201);
        check("t2_b2b_01", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
        check("t2_b2b_12", 64'(got_cyc[2] - got_cyc[1]), 64'd1);
        got.delete();
        got_cyc.delete();

        // 64-bit full reversal, then enabled=0 override
        start_b(3, 1, 1'b1);
        send_b(64'h0011223344556677);
        check("t3_rev_valid", 64'(b_out.valid), 64'd1);
        check("t3_rev_data",  b_out.data, 64'h7766554433221100);
        wait_done("t3a", 1'b1);
        start_b(3, 1, 1'b0);
        send_b(64'h0011223344556677);
        check("t3_dis_data", b_out.data, 64'h0011223344556677);
        wait_done("t3b", 1'b1);
        step();

        // Output stall for three cycles mid-run fills the skid
        d0 = a_done_cnt;
        start_a(3, 4, 1'b1);
        a_in.data  = 32'h01020304;
        a_in.valid = 1'b1;
        check("t4_ready_first", 64'(a_in.ready), 64'd1);
        step();
        a_out.ready = 1'b0;
        a_in.data   = 32'h05060708;
        step();
        check("t4_skid_ready_low", 64'(a_in.ready), 64'd0);
        check("t4_hold_1", 64'(a_out.data), 64'h04030201);
        a_in.data = 32'h090A0B0C;
        step();
        check("t4_hold_2", 64'(a_out.data), 64'h04030201);
        check("t4_hold_valid", 64'(a_out.valid), 64'd1);
        step();
        check("t4_hold_3", 64'(a_out.data), 64'h04030201);
        check("t4_ready_still_low", 64'(a_in.ready), 64'd0);
        a_out.ready = 1'b1;
        step();
        check("t4_skid_to_out", 64'(a_out.data), 64'h08070605);
        send_a(32'h090A0B0C);
        send_a(32'h0D0E0F10);
        wait_done("t4", 1'b0);
        step();
        check("t4_beats", 64'(got.size()), 64'd4);
        check("t4_beat0", 64'(got[0]), 64'h04030201);
        check("t4_beat1", 64'(got[1]), 64'h08070605);
        check("t4_beat2", 64'(got[2]), 64'h0C0B0A09);
        check("t4_beat3", 64'(got[3]), 64'h100F0E0D);
        check("t4_done_once", 64'(a_done_cnt - d0), 64'd1);
        got.delete();
        got_cyc.delete();

        // len=0 gives an immediate done; run while busy is ignored
        start_a(0, 0, 1'b1);
        check("t5_len0_done", 64'(a_done), 64'd1);
        check("t5_len0_busy", 64'(a_busy), 64'd0);
        step();
        check("t5_len0_done_clear", 64'(a_done), 64'd0);
        d0 = a_done_cnt;
        start_a(0, 2, 1'b1);
        a_mode = MODE_W'(1);
        a_len  = 16'd0;
        a_run  = 1'b1;
        step();
        a_run  = 1'b0;
        check("t5_busy_run_busy",  64'(a_busy),     64'd1);
        check("t5_busy_run_done",  64'(a_done),     64'd0);
        check("t5_busy_run_ready", 64'(a_in.ready), 64'd1);
        send_a(32'hA1B2C3D4);
        send_a(32'h0F1E2D3C);
        wait_done("t5", 1'b0);
        step();
        check("t5_beats", 64'(got.size()), 64'd2);
        check("t5_beat0", 64'(got[0]), 64'hA1B2C3D4);
        check("t5_beat1", 64'(got[1]), 64'h0F1E2D3C);
        check("t5_done_once", 64'(a_done_cnt - d0), 64'd1);
        got.delete();
        got_cyc.delete();

        // Reset during ACTIVE after 2 of 5 beats
        start_a(0, 5, 1'b1);
        send_a(32'h00000001);
        send_a(32'h00000002);
        d0 = a_done_cnt;
        rst = 1'b0;
        #1;
        check("t6_out_valid", 64'(a_out.valid), 64'd0);
        check("t6_out_data",  64'(a_out.data),  64'd0);
        check("t6_busy",      64'(a_busy),      64'd0);
        check("t6_in_ready",  64'(a_in.ready),  64'd0);
        step();
        step();
        step();
        check("t6_no_done", 64'(a_done_cnt - d0), 64'd0);
        rst = 1'b1;
        step();
        got.delete();
        got_cyc.delete();
        start_a(1, 1, 1'b1);
        send_a(32'hCAFEBABE);
        wait_done("t6", 1'b0);
        check("t6_new_run_beats", 64'(got.size()), 64'd1);
        check("t6_new_run_beat0", 64'(got[0]), 64'hFECABEBA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_endian_swap_stream
